prbs_checker: RTL

//  Receive-side checker for the 8-bit pseudo-random bit stream made by the team's LFSR generator.

---
 rtl/prbs_checker_if.sv | 21 ++
 rtl/prbs_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/prbs_checker_if.sv
// Stream and status bundle between a PRBS source (master) and the checker (slave).
interface prbs_checker_if #(
    parameter int ERR_W = 16
);
    logic             clear_i;
    logic             valid_i;
    logic             bit_i;
    logic             locked_o;
    logic             err_o;
    logic [ERR_W-1:0] err_count_o;

    modport master (
        output clear_i, valid_i, bit_i,
        input  locked_o, err_o, err_count_o
    );

    modport slave (
        input  clear_i, valid_i, bit_i,
        output locked_o, err_o, err_count_o
    );
endinterface

// File: rtl/prbs_checker.sv
// Receive-side checker for the 8-bit PRBS b[n] = b[n-1]^b[n-6]^b[n-7]^b[n-8].
// Fills its reference register from the line, verifies a run of correct
// predictions, then free-runs the reference and counts line bit errors.
module prbs_checker #(
    parameter int LOCK_BITS = 16,
    parameter int WINDOW    = 64,
    parameter int LOSS_ERRS = 4,
    parameter int ERR_W     = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    prbs_checker_if.slave  bus
);

    // The FILL phase counts to 8, so the shared counter needs at least 4 bits.
    localparam int CNT_W  = (LOCK_BITS > 8) ? $clog2(LOCK_BITS + 1) : 4;
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int WERR_W = $clog2(LOSS_ERRS + 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_VERIFY,
        ST_LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;        // fill count in FILL, match count in VERIFY
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic               pred;
    logic               mismatch;
    logic               counted;
    logic [7:0]         s_line;
    logic [WIN_W-1:0]   win_cnt_inc;
    logic [WERR_W-1:0]  win_err_inc;

    assign pred        = s_q[0] ^ s_q[5] ^ s_q[6] ^ s_q[7];
    assign mismatch    = bus.valid_i & (bus.bit_i != pred);
    assign s_line      = {s_q[6:0], bus.bit_i};
    assign win_cnt_inc = win_cnt_q + 1'b1;
    assign win_err_inc = win_err_q + {{(WERR_W-1){1'b0}}, mismatch};

    // Next-state and output logic for the FILL / VERIFY / LOCKED sequence.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        counted     = 1'b0;

        if (bus.valid_i) begin
            case (state_q)
                ST_FILL: begin
                    s_d = s_line;
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (s_line != 8'h00) begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_VERIFY: begin
                    s_d = s_line;
                    if (s_line == 8'h00) begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                    end else if (mismatch) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(LOCK_BITS - 1)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_LOCKED: begin
                    // Reference free-runs so a single line error costs one mismatch.
                    s_d = {s_q[6:0], pred};
                    if (mismatch) begin
                        err_d   = 1'b1;
                        counted = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end
                    if (win_err_inc == WERR_W'(LOSS_ERRS)) begin
                        state_d   = ST_FILL;
                        locked_d  = 1'b0;
                        cnt_d     = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_inc == WIN_W'(WINDOW)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_inc;
                        win_err_d = win_err_inc;
                    end
                end

                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end

        // A clear coinciding with a counted error leaves that error in the count.
        if (bus.clear_i) begin
            err_count_d = counted ? ERR_W'(1) : '0;
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_FILL;
            s_q         <= '0;
            cnt_q       <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.locked_o    = locked_q;
    assign bus.err_o       = err_q;
    assign bus.err_count_o = err_count_q;

endmodule
